// File: rtl/cdc_handshake_rx_if.sv
// Bus bundle for the receive side of a four-phase req/ack multi-bit crossing.
// master = source/consumer side (testbench or neighbours), slave = cdc_handshake_rx.
interface cdc_handshake_rx_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
);
    logic             reqIn;
    logic [N-1:0]     dataIn;
    logic             ackOut;
    logic [N-1:0]     dataOut;
    logic             dataValid;
    logic             dataReady;
    logic [CNT_W-1:0] xferCount;
    logic             protoErr;

    modport master (
        output reqIn, dataIn, dataReady,
        input  ackOut, dataOut, dataValid, xferCount, protoErr
    );

    modport slave (
        input  reqIn, dataIn, dataReady,
        output ackOut, dataOut, dataValid, xferCount, protoErr
    );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination-side four-phase req/ack controller for multi-bit clock-domain crossings.
// Optional protocol checker enabled by defining CDC_RX_PROTO_CHECK_EN.
module cdc_handshake_rx #(
    parameter int unsigned N           = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    cdc_handshake_rx_if.slave bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $error("cdc_handshake_rx: SYNC_STAGES must be in 2..4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_s;
    logic [N-1:0]           data_q;
    logic                   valid_q;
    logic                   ack_q;
    logic [CNT_W-1:0]       cnt_q;

    // Request synchronizer; only stage 0 ever looks at the asynchronous reqIn.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], bus.reqIn};
        end
    end

    assign req_s = req_sync[SYNC_STAGES-1];

    // Handshake FSM; dataIn is sampled only in the IDLE->HOLD capture cycle,
    // when the synchronized request guarantees it has been stable for several cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_s) begin
                        data_q  <= bus.dataIn;
                        valid_q <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (valid_q && bus.dataReady) begin
                        valid_q <= 1'b0;
                        ack_q   <= 1'b1;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state   <= ACK;
                    end
                end
                ACK: begin
                    if (!req_s) begin
                        ack_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    ack_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ackOut    = ack_q;
    assign bus.dataOut   = data_q;
    assign bus.dataValid = valid_q;
    assign bus.xferCount = cnt_q;

`ifdef CDC_RX_PROTO_CHECK_EN
    logic perr_q;

    // Sticky flag: request withdrawn before ack, or ack still high in IDLE (fault only).
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if ((state == HOLD && !req_s) || (state == IDLE && ack_q)) begin
            perr_q <= 1'b1;
        end
    end

    assign bus.protoErr = perr_q;
`else
    assign bus.protoErr = 1'b0;
`endif

endmodule

// File: doc/cdc_handshake_rx.md
Name: cdc_handshake_rx

Overview:
- Receive-side controller for a multi-bit clock-domain crossing using a four-phase req/ack handshake.
- Synchronizes the asynchronous request through a chain of flops and captures the quasi-static data bus only once the request is synchronized.
- Presents the captured word to a local consumer with valid/ready, and returns an acknowledge to the source domain.
- Sits at the destination edge of every multi-bit crossing; single-bit crossings keep using plain flop synchronizers.

Parameters:
- N, 8, data width in bits.
- SYNC_STAGES, 2, number of request synchronizer flops; legal range is 2..4.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  destination-domain clock.
- rst  input  1  synchronous, active-high reset.
- reqIn  input  1  asynchronous four-phase request from the source domain.
- dataIn  input  N  asynchronous data; the source holds it stable from reqIn rise until it sees ackOut rise.
- ackOut  output  1  four-phase acknowledge to the source domain; driven directly from a flop.
- dataOut  output  N  captured word.
- dataValid  output  1  dataOut holds an unconsumed word.
- dataReady  input  1  consumer accepts the word when high together with dataValid.
- xferCount  output  CNT_W  number of completed transfers.
- protoErr  output  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Clock and reset:
  - All flops update on posedge clk.
  - rst=1 at an edge clears the sync chain, dataOut, dataValid, ackOut, xferCount and protoErr to 0, and sets state=IDLE.
- Synchronizer:
  - reqIn passes through SYNC_STAGES flops; reqS is the last stage.
  - Nothing other than the first stage samples reqIn directly.
  - dataIn is never synchronized; it is sampled only in the capture cycle.
- FSM states: IDLE, HOLD, ACK.
  - IDLE, reqS=1: dataOut<=dataIn, dataValid<=1, go to HOLD.
  - IDLE, reqS=0: remain in IDLE.
  - HOLD, dataValid&dataReady: dataValid<=0, ackOut<=1, xferCount<=xferCount+1, go to ACK.
  - HOLD, otherwise: hold all outputs.
  - ACK, reqS=0: ackOut<=0, go to IDLE.
  - ACK, reqS=1: remain in ACK.
- Latency:
  - Let E1 be the first edge at which reqIn=1 is sampled. dataValid is high after edge E(SYNC_STAGES+1); for the default that is 3 edges.
  - Consumer accept at edge Ea: ackOut is high after Ea, a 0-cycle ready-to-ack turnaround.
  - reqIn fall sampled at edge Ef: ackOut is low after edge Ef+SYNC_STAGES.
  - Minimum back-to-back: a new capture occurs no earlier than the edge after ackOut falls, because IDLE requires reqS=1 again.
- dataReady while dataValid=0 has no effect. dataOut holds its value from capture until the next capture; consumption does not clear it.
- xferCount wraps from 2^CNT_W-1 to 0 with no flag.
- Protocol violation: reqS falling while in HOLD.
  - The held word remains valid and is delivered normally.
  - The FSM still goes to ACK on accept; in ACK, reqS=0 returns it to IDLE one edge later.
- Reset mid-operation:
  - ackOut drops and any held word is discarded.
  - If reqIn is still high after reset release, the word is re-captured. This duplicate is permitted, and the source must tolerate it.
- Simultaneous rst with any other event: rst wins.

Optional Feature:
- Macro: CDC_RX_PROTO_CHECK_EN.
- Defined:
  - protoErr<=1 on the edge where state=HOLD and reqS=0.
  - protoErr<=1 on the edge where state=IDLE and ackOut=1; this is unreachable and exists for fault detection.
  - protoErr stays 1 until rst.
- Undefined: protoErr is tied to constant 0 and the check logic is not built.

Test Plan:
- Basic transfer: reset, then dataIn=8'hA5, reqIn=1, dataReady=1 -> dataValid rises 3 edges after reqIn is first sampled and dataOut=8'hA5. On the same accept edge, ackOut=1 and xferCount=1. Drop reqIn -> ackOut=0 two edges later; state=IDLE.
- Consumer backpressure: dataReady=0 for 10 cycles after dataValid -> dataValid stays 1, dataOut stays stable, ackOut stays 0. Raise dataReady -> ackOut=1 on the next edge.
- Back-to-back: 4 handshakes with 8'h01, 8'h02, 8'h03, 8'h04 -> consumer receives exactly these 4 words in order, xferCount=4, no duplicates.
- Data change guard: change dataIn after capture but before ackOut rises (an illegal source) -> dataOut keeps the captured value.
- Protocol error with CDC_RX_PROTO_CHECK_EN defined: drop reqIn while in HOLD -> protoErr=1 SYNC_STAGES edges later, stays 1 through further transfers, clears only on rst. Without the macro, the same stimulus gives protoErr=0.
- Reset mid-operation: assert rst for 1 cycle in ACK -> all outputs 0 and state IDLE after that edge. With reqIn held high, a re-capture occurs and dataValid=1 3 edges after reset release. CNT_W=4 with 17 transfers -> xferCount=1 (wrap).
